// File: rtl/cdc_2phase_resp.sv
// cdc_2phase_resp: local-domain responder for a two-phase (toggle)
// request/acknowledge interface. The request toggle is synchronised, the
// quasi-static payload is captured and offered as a valid/ready stream; the
// local response is returned with the payload and the acknowledge toggle
// updated on the same edge.
// Optional build macro: CDC_2PHASE_RESP_TIMEOUT_EN adds a WAIT_RSP watchdog
// that forces an error acknowledge after TimeoutCycles cycles.
module cdc_2phase_resp #(
    parameter type         ReqT          = logic,
    parameter type         RspT          = logic,
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     async_req_i,
    input  logic [$bits(ReqT)-1:0]   async_req_data_i,
    output logic                     async_ack_o,
    output logic [$bits(RspT)-1:0]   async_rsp_data_o,
    output logic                     async_err_o,
    output logic [$bits(ReqT)-1:0]   req_o,
    output logic                     req_valid_o,
    input  logic                     req_ready_i,
    input  logic [$bits(RspT)-1:0]   rsp_i,
    input  logic                     rsp_valid_i,
    output logic                     rsp_ready_o,
    output logic                     busy_o
);

    localparam int unsigned ReqW = $bits(ReqT);
    localparam int unsigned RspW = $bits(RspT);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;

    // Parameter sanity: a single-flop synchroniser is not metastability safe,
    // and a one-cycle watchdog would fire before a response could arrive.
    if (SyncStages < 2) begin : g_chk_sync
        $error("cdc_2phase_resp: SyncStages must be at least 2");
    end
    if (TimeoutCycles < 2) begin : g_chk_tmo
        $error("cdc_2phase_resp: TimeoutCycles must be at least 2");
    end

    logic [SyncStages-1:0] sync_q;
    logic                  req_sync;
    logic                  pending;
    logic [1:0]            state_q;
    logic [ReqW-1:0]       req_q;
    logic                  ack_q;
    logic [RspW-1:0]       rsp_q;
    logic                  err_q;

    // Synchroniser chain for the asynchronous request toggle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], async_req_i};
        end
    end

    assign req_sync = sync_q[SyncStages-1];
    // A new transaction is outstanding whenever the request parity differs
    // from the acknowledge parity; toggling ack_q consumes it.
    assign pending  = (req_sync != ack_q);

`ifdef CDC_2PHASE_RESP_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    logic [CntW-1:0] tmo_q;
    logic            tmo_expire;

    assign tmo_expire = (tmo_q == CntW'(TimeoutCycles - 1));

    // Watchdog: cleared on entry to WAIT_RSP, counts cycles without a response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else if (state_q == REQ && req_ready_i) begin
            tmo_q <= '0;
        end else if (state_q == WAIT_RSP && !rsp_valid_i) begin
            tmo_q <= tmo_q + CntW'(1);
        end
    end
`endif

    // Transaction FSM: capture request, hand it to local logic, return response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            ack_q   <= 1'b0;
            rsp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending) begin
                        req_q   <= async_req_data_i;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (req_ready_i) begin
                        state_q <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // Payload and ack change together; the initiator only
                    // looks at the payload after synchronising the ack.
                    if (rsp_valid_i) begin
                        rsp_q   <= rsp_i;
                        err_q   <= 1'b0;
                        ack_q   <= ~ack_q;
                        state_q <= IDLE;
                    end
`ifdef CDC_2PHASE_RESP_TIMEOUT_EN
                    else if (tmo_expire) begin
                        rsp_q   <= '0;
                        err_q   <= 1'b1;
                        ack_q   <= ~ack_q;
                        state_q <= IDLE;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign async_ack_o      = ack_q;
    assign async_rsp_data_o = rsp_q;
    assign async_err_o      = err_q;
    assign req_o            = req_q;
    assign req_valid_o      = (state_q == REQ);
    assign rsp_ready_o      = (state_q == WAIT_RSP);
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_2phase_resp.sv
// Testbench for cdc_2phase_resp: table-driven transactions, randomized
// transactions against a transaction-level model (request FIFO and ack
// parity), and hand-written reset / timeout sequences.
module tb_cdc_2phase_resp;

    localparam int SYNC   = 2;
    localparam int TMO    = 8;
    localparam int EXPLAT = SYNC + 1;

    logic       clk;
    logic       rst_n;
    logic       async_req;
    logic [7:0] async_req_data;
    logic       async_ack;
    logic [7:0] async_rsp_data;
    logic       async_err;
    logic [7:0] req;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] rsp;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       busy;

    cdc_2phase_resp #(
        .ReqT          (logic [7:0]),
        .RspT          (logic [7:0]),
        .SyncStages    (SYNC),
        .TimeoutCycles (TMO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .async_req_i      (async_req),
        .async_req_data_i (async_req_data),
        .async_ack_o      (async_ack),
        .async_rsp_data_o (async_rsp_data),
        .async_err_o      (async_err),
        .req_o            (req),
        .req_valid_o      (req_valid),
        .req_ready_i      (req_ready),
        .rsp_i            (rsp),
        .rsp_valid_i      (rsp_valid),
        .rsp_ready_o      (rsp_ready),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rd;
        logic [7:0] rs;
        int         rdy_dly;
        int         rsp_dly;
        bit         spur;
        logic [7:0] exp_req;
        logic [7:0] exp_rsp;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         hs_cnt  = 0;
    int         acc_cnt = 0;
    logic       parity  = 1'b0;
    logic [7:0] sent_q[$];

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) hs_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] rd, output int lat);
        logic [7:0] exp;
        @(negedge clk);
        async_req_data = rd;
        async_req      = ~async_req;
        sent_q.push_back(rd);
        lat = 0;
        while (lat < 16) begin
            @(posedge clk);
            lat++;
            #1;
            if (req_valid === 1'b1) break;
        end
        exp = sent_q.pop_front();
        check("req_order", req, exp);
    endtask

    task automatic accept();
        @(negedge clk);
        rsp_valid = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        acc_cnt++;
    endtask

    task automatic respond(input logic [7:0] rs, input int dly);
        repeat (dly) @(negedge clk);
        rsp       = rs;
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        logic old_ack;
        int   lat;
        bit   ok;
        old_ack = async_ack;
        ok = 1'b1;
        if (v.spur) begin
            @(negedge clk);
            rsp       = 8'hEE;
            rsp_valid = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (rsp_ready !== 1'b0 || async_ack !== old_ack || busy !== 1'b0) ok = 1'b0;
            end
        end
        send_req(v.rd, lat);
        check("latency", lat, EXPLAT);
        check("req_data", req, v.exp_req);
        repeat (v.rdy_dly) begin
            @(negedge clk);
            if (req_valid !== 1'b1 || req !== v.exp_req || busy !== 1'b1 ||
                rsp_ready !== 1'b0 || async_ack !== old_ack) ok = 1'b0;
        end
        check("hold_stable", ok, 1);
        accept();
        check("wait_state", {rsp_ready, req_valid, busy}, 3'b101);
        check("ack_before_rsp", async_ack, old_ack);
        respond(v.rs, v.rsp_dly);
        parity = ~parity;
        check("ack", async_ack, parity);
        check("rsp_data", async_rsp_data, v.exp_rsp);
        check("err", async_err, 0);
        check("idle", {busy, rsp_ready, req_valid}, 3'b000);
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (req_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        check("no_retrigger", ok, 1);
    endtask

    vec_t tbl[7];

    initial begin
        vec_t v;
        int   lat;
        int   cnt;
        bit   ok;
        logic old_ack;

        tbl[0] = '{8'h01, 8'h81, 0, 0, 1'b0, 8'h01, 8'h81};
        tbl[1] = '{8'h02, 8'h82, 0, 0, 1'b0, 8'h02, 8'h82};
        tbl[2] = '{8'h03, 8'h83, 0, 0, 1'b0, 8'h03, 8'h83};
        tbl[3] = '{8'h04, 8'h84, 0, 0, 1'b0, 8'h04, 8'h84};
        tbl[4] = '{8'hA5, 8'h3C, 0, 1, 1'b0, 8'hA5, 8'h3C};
        tbl[5] = '{8'h5E, 8'hC7, 20, 2, 1'b0, 8'h5E, 8'hC7};
        tbl[6] = '{8'h96, 8'h69, 3, 0, 1'b1, 8'h96, 8'h69};

        rst_n          = 1'b0;
        async_req      = 1'b0;
        async_req_data = 8'h00;
        req_ready      = 1'b0;
        rsp            = 8'h00;
        rsp_valid      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vals", {async_ack, async_rsp_data, async_err, req, req_valid, rsp_ready, busy}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i]);
            if (i == 3) check("parity_after_4", async_ack, 0);
        end

        for (int i = 0; i < 24; i++) begin
            v.rd      = 8'($urandom);
            v.rs      = 8'($urandom);
            v.rdy_dly = $urandom_range(0, 4);
            v.rsp_dly = $urandom_range(0, 5);
            v.spur    = 1'($urandom_range(0, 1));
            v.exp_req = v.rd;
            v.exp_rsp = v.rs;
            run_txn(v);
        end

`ifdef CDC_2PHASE_RESP_TIMEOUT_EN
        send_req(8'h11, lat);
        accept();
        old_ack = async_ack;
        cnt = 0;
        while (cnt < 40) begin
            @(posedge clk);
            cnt++;
            #1;
            if (async_ack !== old_ack) break;
        end
        parity = ~parity;
        check("tmo_cycles", cnt, TMO);
        check("tmo_ack", async_ack, parity);
        check("tmo_err", async_err, 1);
        check("tmo_data", async_rsp_data, 0);
        check("tmo_idle", busy, 0);
        ok = 1'b1;
        @(negedge clk);
        rsp       = 8'hBB;
        rsp_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (rsp_ready !== 1'b0 || async_ack !== parity) ok = 1'b0;
        end
        rsp_valid = 1'b0;
        check("late_rsp_ignored", ok, 1);

        send_req(8'h22, lat);
        accept();
        respond(8'h5A, TMO - 1);
        parity = ~parity;
        check("edge_rsp_ack", async_ack, parity);
        check("edge_rsp_err", async_err, 0);
        check("edge_rsp_data", async_rsp_data, 8'h5A);
`endif

        send_req(8'h77, lat);
        accept();
        check("pre_reset_wait", {rsp_ready, busy}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_vals", {async_ack, async_rsp_data, async_err, req, req_valid, rsp_ready, busy}, 0);
        async_req = 1'b0;
        parity    = 1'b0;
        repeat (3) @(negedge clk);
        check("held_reset_vals", {async_ack, async_rsp_data, async_err, req, req_valid, rsp_ready, busy}, 0);
        rst_n = 1'b1;
        v = '{8'h99, 8'h66, 1, 1, 1'b0, 8'h99, 8'h66};
        run_txn(v);

        check("handshakes", hs_cnt, acc_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
